// File: rtl/axis_frame_len_stats_pkg.sv
// Shared constants for the frame-length statistics block: histogram bin edges and bin count.
package axis_frame_len_stats_pkg;

  localparam int HIST_BINS     = 4;
  localparam int HIST_BIN0_MAX = 127;
  localparam int HIST_BIN1_MAX = 511;
  localparam int HIST_BIN2_MAX = 1023;

endpackage

// File: rtl/axis_frame_len_stats_if.sv
// Result-pulse bus from the AXIS length monitor into the statistics block.
// Handshake: frame_len is qualified by frame_len_valid, a one-cycle pulse per frame.
// There is no ready; the consumer absorbs every pulse in the cycle it arrives.
interface axis_frame_len_stats_if #(
  parameter int LEN_WIDTH = 16
);
  logic [LEN_WIDTH-1:0] frame_len;
  logic                 frame_len_valid;

  modport master (output frame_len, output frame_len_valid);
  modport slave  (input  frame_len, input  frame_len_valid);
endinterface

// File: rtl/axis_stat_sat_counter.sv
// Saturating accumulator; count shows the value after this cycle's increment so a
// snapshot taken in the same cycle includes the coincident sample.
module axis_stat_sat_counter #(
  parameter int WIDTH     = 32,
  parameter int INC_WIDTH = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 clr,
  input  logic                 inc_en,
  input  logic [INC_WIDTH-1:0] inc_val,
  output logic [WIDTH-1:0]     count
);

  logic [WIDTH-1:0] count_q;
  logic [WIDTH:0]   sum;

  always_comb begin
    sum   = {1'b0, count_q} + (WIDTH+1)'(inc_val);
    count = count_q;
    if (inc_en) begin
      count = sum[WIDTH] ? '1 : sum[WIDTH-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      count_q <= '0;
    end else begin
      count_q <= count;
    end
  end

endmodule

// File: rtl/axis_frame_len_stats.sv
// Per-interval frame-length statistics with snapshot/clear.
// Optional histogram enabled by defining AXIS_FRAME_LEN_STATS_HIST_EN.
module axis_frame_len_stats
  import axis_frame_len_stats_pkg::*;
#(
  parameter int LEN_WIDTH   = 16,
  parameter int COUNT_WIDTH = 32,
  parameter int BYTES_WIDTH = 48,
  parameter int MIN_LEN     = 64,
  parameter int MAX_LEN     = 1518
) (
  input  logic                           clk,
  input  logic                           rst,
  axis_frame_len_stats_if.slave          len_if,
  input  logic                           snapshot_req,
  input  logic                           snapshot_clear,
  output logic [COUNT_WIDTH-1:0]         stat_frames,
  output logic [BYTES_WIDTH-1:0]         stat_bytes,
  output logic [LEN_WIDTH-1:0]           stat_min_len,
  output logic [LEN_WIDTH-1:0]           stat_max_len,
  output logic [COUNT_WIDTH-1:0]         stat_runt,
  output logic [COUNT_WIDTH-1:0]         stat_oversize,
  output logic [HIST_BINS*COUNT_WIDTH-1:0] stat_hist,
  output logic                           stat_valid
);

  logic                   sample;
  logic [LEN_WIDTH-1:0]   len;
  logic                   clr_live;
  logic                   is_runt;
  logic                   is_over;

  assign sample   = len_if.frame_len_valid;
  assign len      = len_if.frame_len;
  assign clr_live = snapshot_req & snapshot_clear;
  assign is_runt  = len < LEN_WIDTH'(MIN_LEN);
  assign is_over  = len > LEN_WIDTH'(MAX_LEN);

  logic [COUNT_WIDTH-1:0] frames_next, runt_next, over_next;
  logic [BYTES_WIDTH-1:0] bytes_next;

  axis_stat_sat_counter #(.WIDTH(COUNT_WIDTH), .INC_WIDTH(1)) u_frames (
    .clk(clk), .rst(rst), .clr(clr_live), .inc_en(sample), .inc_val(1'b1), .count(frames_next)
  );
  axis_stat_sat_counter #(.WIDTH(BYTES_WIDTH), .INC_WIDTH(LEN_WIDTH)) u_bytes (
    .clk(clk), .rst(rst), .clr(clr_live), .inc_en(sample), .inc_val(len), .count(bytes_next)
  );
  axis_stat_sat_counter #(.WIDTH(COUNT_WIDTH), .INC_WIDTH(1)) u_runt (
    .clk(clk), .rst(rst), .clr(clr_live), .inc_en(sample & is_runt), .inc_val(1'b1), .count(runt_next)
  );
  axis_stat_sat_counter #(.WIDTH(COUNT_WIDTH), .INC_WIDTH(1)) u_over (
    .clk(clk), .rst(rst), .clr(clr_live), .inc_en(sample & is_over), .inc_val(1'b1), .count(over_next)
  );

  // Min/max: *_next already folds in the current sample, mirroring the counters.
  logic [LEN_WIDTH-1:0] min_live, max_live, min_next, max_next;

  assign min_next = (sample && (len < min_live)) ? len : min_live;
  assign max_next = (sample && (len > max_live)) ? len : max_live;

  always_ff @(posedge clk) begin
    if (rst || clr_live) begin
      min_live <= '1;
      max_live <= '0;
    end else begin
      min_live <= min_next;
      max_live <= max_next;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stat_frames   <= '0;
      stat_bytes    <= '0;
      stat_min_len  <= '1;
      stat_max_len  <= '0;
      stat_runt     <= '0;
      stat_oversize <= '0;
      stat_valid    <= 1'b0;
    end else begin
      stat_valid <= snapshot_req;
      if (snapshot_req) begin
        stat_frames   <= frames_next;
        stat_bytes    <= bytes_next;
        stat_min_len  <= min_next;
        stat_max_len  <= max_next;
        stat_runt     <= runt_next;
        stat_oversize <= over_next;
      end
    end
  end

`ifdef AXIS_FRAME_LEN_STATS_HIST_EN
  logic [HIST_BINS-1:0]             bin_hit;
  logic [HIST_BINS*COUNT_WIDTH-1:0] hist_next;

  always_comb begin
    bin_hit = '0;
    if (len <= LEN_WIDTH'(HIST_BIN0_MAX))      bin_hit[0] = 1'b1;
    else if (len <= LEN_WIDTH'(HIST_BIN1_MAX)) bin_hit[1] = 1'b1;
    else if (len <= LEN_WIDTH'(HIST_BIN2_MAX)) bin_hit[2] = 1'b1;
    else                                       bin_hit[3] = 1'b1;
  end

  for (genvar b = 0; b < HIST_BINS; b++) begin : g_hist
    axis_stat_sat_counter #(.WIDTH(COUNT_WIDTH), .INC_WIDTH(1)) u_bin (
      .clk(clk), .rst(rst), .clr(clr_live), .inc_en(sample & bin_hit[b]), .inc_val(1'b1),
      .count(hist_next[b*COUNT_WIDTH +: COUNT_WIDTH])
    );
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stat_hist <= '0;
    end else if (snapshot_req) begin
      stat_hist <= hist_next;
    end
  end
`else
  assign stat_hist = '0;
`endif

endmodule

// File: tb/tb_axis_frame_len_stats.sv
// Directed bench for axis_frame_len_stats: a default-width instance plus a narrow
// instance for saturation. Expected values are hand-computed constants.
module tb_axis_frame_len_stats;

  localparam int LW  = 16;
  localparam int CW  = 32;
  localparam int BW  = 48;
  localparam int SCW = 4;
  localparam int SBW = 16;

`ifdef AXIS_FRAME_LEN_STATS_HIST_EN
  localparam logic [4*CW-1:0]  EXP_HIST_EDGES = {32'd1, 32'd1, 32'd1, 32'd1};
  localparam logic [4*SCW-1:0] EXP_S_HIST     = {4'd15, 4'd0, 4'd0, 4'd0};
`else
  localparam logic [4*CW-1:0]  EXP_HIST_EDGES = '0;
  localparam logic [4*SCW-1:0] EXP_S_HIST     = '0;
`endif

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // ---------------- main instance ----------------
  axis_frame_len_stats_if #(.LEN_WIDTH(LW)) m_if ();
  logic              req, sclr;
  logic [CW-1:0]     frames, runt, over;
  logic [BW-1:0]     bytes;
  logic [LW-1:0]     min_len, max_len;
  logic [4*CW-1:0]   hist;
  logic              valid;

  axis_frame_len_stats #(
    .LEN_WIDTH(LW), .COUNT_WIDTH(CW), .BYTES_WIDTH(BW), .MIN_LEN(64), .MAX_LEN(1518)
  ) dut (
    .clk(clk), .rst(rst), .len_if(m_if.slave),
    .snapshot_req(req), .snapshot_clear(sclr),
    .stat_frames(frames), .stat_bytes(bytes), .stat_min_len(min_len), .stat_max_len(max_len),
    .stat_runt(runt), .stat_oversize(over), .stat_hist(hist), .stat_valid(valid)
  );

  // ---------------- narrow instance (saturation) ----------------
  axis_frame_len_stats_if #(.LEN_WIDTH(LW)) s_if ();
  logic              s_req, s_sclr;
  logic [SCW-1:0]    s_frames, s_runt, s_over;
  logic [SBW-1:0]    s_bytes;
  logic [LW-1:0]     s_min, s_max;
  logic [4*SCW-1:0]  s_hist;
  logic              s_valid;

  axis_frame_len_stats #(
    .LEN_WIDTH(LW), .COUNT_WIDTH(SCW), .BYTES_WIDTH(SBW), .MIN_LEN(64), .MAX_LEN(1518)
  ) dut_sat (
    .clk(clk), .rst(rst), .len_if(s_if.slave),
    .snapshot_req(s_req), .snapshot_clear(s_sclr),
    .stat_frames(s_frames), .stat_bytes(s_bytes), .stat_min_len(s_min), .stat_max_len(s_max),
    .stat_runt(s_runt), .stat_oversize(s_over), .stat_hist(s_hist), .stat_valid(s_valid)
  );

  // ---------------- checking ----------------
  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // ---------------- drivers ----------------
  task automatic send(input logic [LW-1:0] l);
    @(negedge clk);
    m_if.frame_len       = l;
    m_if.frame_len_valid = 1'b1;
    @(negedge clk);
    m_if.frame_len_valid = 1'b0;
  endtask

  task automatic snap(input logic clr);
    @(negedge clk);
    req  = 1'b1;
    sclr = clr;
    @(negedge clk);
    req  = 1'b0;
    sclr = 1'b0;
    check("stat_valid_pulse", valid, 1);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    rst = 1'b1;
    req = 1'b0; sclr = 1'b0;
    m_if.frame_len = '0; m_if.frame_len_valid = 1'b0;
    s_req = 1'b0; s_sclr = 1'b0;
    s_if.frame_len = '0; s_if.frame_len_valid = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;

    // reset state
    check("rst_valid",  valid,   0);
    check("rst_frames", frames,  0);
    check("rst_min",    min_len, 16'hFFFF);
    check("rst_max",    max_len, 0);
    check("rst_hist",   hist,    0);

    // empty snapshots with clear
    snap(1'b1);
    check("empty_frames", frames,  0);
    check("empty_bytes",  bytes,   0);
    check("empty_min",    min_len, 16'hFFFF);
    check("empty_max",    max_len, 0);
    snap(1'b1);
    check("empty2_frames", frames,  0);
    check("empty2_min",    min_len, 16'hFFFF);

    // basic mix: 64 + 1518 + 60 + 1600 = 3242
    send(16'd64); send(16'd1518); send(16'd60); send(16'd1600);
    snap(1'b1);
    check("mix_frames", frames,  4);
    check("mix_bytes",  bytes,   3242);
    check("mix_min",    min_len, 60);
    check("mix_max",    max_len, 1600);
    check("mix_runt",   runt,    1);
    check("mix_over",   over,    1);
    @(negedge clk);
    check("valid_drop", valid,   0);
    check("mix_hold",   frames,  4);

    // sample coincident with snapshot+clear lands in the snapshot
    @(negedge clk);
    m_if.frame_len = 16'd100; m_if.frame_len_valid = 1'b1;
    req = 1'b1; sclr = 1'b1;
    @(negedge clk);
    m_if.frame_len_valid = 1'b0; req = 1'b0; sclr = 1'b0;
    check("coin_valid",  valid,   1);
    check("coin_frames", frames,  1);
    check("coin_bytes",  bytes,   100);
    check("coin_min",    min_len, 100);
    snap(1'b0);
    check("coin_after_frames", frames,  0);
    check("coin_after_min",    min_len, 16'hFFFF);

    // snapshots without clear accumulate
    send(16'd200);
    snap(1'b0);
    check("noclr1_frames", frames, 1);
    check("noclr1_bytes",  bytes,  200);
    send(16'd200);
    snap(1'b0);
    check("noclr2_frames", frames, 2);
    check("noclr2_bytes",  bytes,  400);

    // back-to-back requests: second carries the clear
    @(negedge clk);
    req = 1'b1; sclr = 1'b0;
    @(negedge clk);
    check("b2b_valid1",  valid,  1);
    check("b2b_frames1", frames, 2);
    sclr = 1'b1;
    @(negedge clk);
    req = 1'b0; sclr = 1'b0;
    check("b2b_valid2",  valid,  1);
    check("b2b_bytes2",  bytes,  400);
    snap(1'b0);
    check("b2b_after_frames", frames, 0);

    // clear without request is ignored
    send(16'd300);
    @(negedge clk);
    sclr = 1'b1;
    @(negedge clk);
    sclr = 1'b0;
    snap(1'b1);
    check("lone_clear_frames", frames, 1);
    check("lone_clear_bytes",  bytes,  300);

    // histogram bin edges
    send(16'd127); send(16'd128); send(16'd1023); send(16'd1024);
    snap(1'b1);
    check("hist_frames", frames, 4);
    check("hist_bins",   hist,   EXP_HIST_EDGES);
    check("hist_min",    min_len, 127);
    check("hist_max",    max_len, 1024);

    // runt/oversize boundaries: 0+63+64+1518+1519 = 3164
    send(16'd0); send(16'd63); send(16'd64); send(16'd1518); send(16'd1519);
    snap(1'b1);
    check("bound_runt",  runt,    2);
    check("bound_over",  over,    1);
    check("bound_min",   min_len, 0);
    check("bound_max",   max_len, 1519);
    check("bound_bytes", bytes,   3164);

    // saturation on the narrow instance: 20 x 4000 bytes
    @(negedge clk);
    s_if.frame_len = 16'd4000; s_if.frame_len_valid = 1'b1;
    repeat (20) @(negedge clk);
    s_if.frame_len_valid = 1'b0;
    s_req = 1'b1;
    @(negedge clk);
    s_req = 1'b0;
    check("sat_valid",  s_valid,  1);
    check("sat_frames", s_frames, 15);
    check("sat_bytes",  s_bytes,  16'hFFFF);
    check("sat_over",   s_over,   15);
    check("sat_runt",   s_runt,   0);
    check("sat_max",    s_max,    4000);
    check("sat_hist",   s_hist,   EXP_S_HIST);

    // reset mid-interval discards everything
    send(16'd500); send(16'd500); send(16'd500);
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    check("midrst_stat_min", min_len, 16'hFFFF);
    check("midrst_stat_frames", frames, 0);
    snap(1'b0);
    check("midrst_frames", frames,  0);
    check("midrst_bytes",  bytes,   0);
    check("midrst_min",    min_len, 16'hFFFF);
    check("midrst_max",    max_len, 0);
    check("midrst_runt",   runt,    0);
    check("midrst_over",   over,    0);
    check("midrst_sat_frames_live", s_frames, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
